// File: rtl/rob_commit_unit.sv
// ROB commit unit: in-order retirement of up to ISSUE_WIDTH ready entries per
// cycle from the ROB head. Stores are released one per cycle. Mispredicts,
// exceptions and memory-order violations turn into a flush plus PC redirect,
// followed by a fixed recovery window.
module rob_commit_unit #(
  parameter  int ISSUE_WIDTH    = 3,
  parameter  int NO_ROB         = 48,
  parameter  int RECOVER_CYCLES = 4,
  localparam int ROB_IDX_W      = $clog2(NO_ROB)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NO_ROB-1:0]                i_rob_valid,
  input  logic [NO_ROB-1:0]                i_rob_ready,
  input  logic [NO_ROB-1:0]                i_rob_is_store,
  input  logic [NO_ROB-1:0]                i_rob_mispredict,
  input  logic [NO_ROB-1:0]                i_rob_exception,
  input  logic [NO_ROB-1:0]                i_rob_violation,
  input  logic [NO_ROB*32-1:0]             i_rob_pc,
  input  logic [NO_ROB*32-1:0]             i_rob_target,
  input  logic                             i_st_commit_ready,
  output logic                             o_st_commit_valid,
  output logic [ROB_IDX_W-1:0]             o_st_commit_rob_id,
  output logic [ISSUE_WIDTH-1:0]           o_commit_valid,
  output logic [ISSUE_WIDTH*ROB_IDX_W-1:0] o_commit_rob_id,
  output logic [ROB_IDX_W-1:0]             o_rob_head,
  output logic                             o_flush,
  output logic [31:0]                      o_redirect_pc,
  output logic [31:0]                      o_retired_count
);

  localparam int CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam int NUM_W = $clog2(ISSUE_WIDTH + 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_RECOVER} state_t;

  state_t                                  r_state, w_state_nxt;
  logic [CNT_W-1:0]                        r_rcnt;

  // registered outputs
  logic [ROB_IDX_W-1:0]                    r_head;
  logic [ISSUE_WIDTH-1:0]                  r_cv;
  logic [ISSUE_WIDTH-1:0][ROB_IDX_W-1:0]   r_cid;
  logic                                    r_stv;
  logic [ROB_IDX_W-1:0]                    r_stid;
  logic                                    r_flush;
  logic [31:0]                             r_rpc;
  logic [31:0]                             r_retired;

  // head-group evaluation
  logic [ISSUE_WIDTH-1:0][ROB_IDX_W:0]     w_sum;
  logic [ISSUE_WIDTH-1:0][ROB_IDX_W-1:0]   w_idx;
  logic [ISSUE_WIDTH-1:0]                  w_ret;
  logic [NUM_W-1:0]                        w_ret_n;
  logic                                    w_blocked, w_st_used, w_st_v, w_redir;
  logic [ROB_IDX_W-1:0]                    w_st_id;
  logic [31:0]                             w_redir_pc;
  logic [ROB_IDX_W:0]                      w_head_sum;

  // next register values
  logic                                    w_run;
  logic [ISSUE_WIDTH-1:0]                  w_nxt_cv;
  logic [ISSUE_WIDTH-1:0][ROB_IDX_W-1:0]   w_nxt_cid;
  logic                                    w_nxt_stv, w_nxt_flush;
  logic [ROB_IDX_W-1:0]                    w_nxt_stid, w_nxt_head;
  logic [31:0]                             w_nxt_rpc, w_nxt_retired;

  // Walk the slots from the head; the first non-retiring slot ends the group.
  always_comb begin
    w_blocked  = 1'b0;
    w_st_used  = 1'b0;
    w_st_v     = 1'b0;
    w_st_id    = '0;
    w_redir    = 1'b0;
    w_redir_pc = '0;
    w_ret      = '0;
    w_ret_n    = '0;
    w_sum      = '0;
    w_idx      = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      // modular wrap without assuming a power-of-two ROB size
      w_sum[k] = {1'b0, r_head} + (ROB_IDX_W+1)'(k);
      w_idx[k] = (w_sum[k] >= (ROB_IDX_W+1)'(NO_ROB)) ?
                 ROB_IDX_W'(w_sum[k] - (ROB_IDX_W+1)'(NO_ROB)) : w_sum[k][ROB_IDX_W-1:0];
      if (!w_blocked) begin
        if (!(i_rob_valid[w_idx[k]] && i_rob_ready[w_idx[k]])) begin
          w_blocked = 1'b1;
        end else if (i_rob_exception[w_idx[k]] || i_rob_violation[w_idx[k]]) begin
          // faulting entry stays in the ROB and is re-fetched from its own PC
          w_redir    = 1'b1;
          w_redir_pc = i_rob_pc[w_idx[k]*32 +: 32];
          w_blocked  = 1'b1;
        end else if (i_rob_is_store[w_idx[k]] && (w_st_used || !i_st_commit_ready)) begin
          w_blocked = 1'b1;
        end else begin
          w_ret[k] = 1'b1;
          w_ret_n  = w_ret_n + NUM_W'(1);
          if (i_rob_is_store[w_idx[k]]) begin
            w_st_used = 1'b1;
            w_st_v    = 1'b1;
            w_st_id   = w_idx[k];
          end
          if (i_rob_mispredict[w_idx[k]]) begin
            // branch itself commits; fetch restarts at its resolved target
            w_redir    = 1'b1;
            w_redir_pc = i_rob_target[w_idx[k]*32 +: 32];
            w_blocked  = 1'b1;
          end
        end
      end
    end
    w_head_sum = {1'b0, r_head} + (ROB_IDX_W+1)'(w_ret_n);
  end

  // FSM state register and recovery countdown
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_RUN;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_FLUSH)
        r_rcnt <= CNT_W'(RECOVER_CYCLES - 1);
      else if (r_state == S_RECOVER && r_rcnt != '0)
        r_rcnt <= r_rcnt - CNT_W'(1);
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:     if (w_redir) w_state_nxt = S_FLUSH;
      S_FLUSH:   w_state_nxt = S_RECOVER;
      S_RECOVER: if (r_rcnt == '0) w_state_nxt = S_RUN;
      default:   w_state_nxt = S_RUN;
    endcase
  end

  // FSM outputs: retirement only takes effect while running
  always_comb begin
    w_run         = (r_state == S_RUN);
    w_nxt_cv      = w_run ? w_ret : '0;
    w_nxt_cid     = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++)
      if (w_run && w_ret[k]) w_nxt_cid[k] = w_idx[k];
    w_nxt_stv     = w_run && w_st_v;
    w_nxt_stid    = w_nxt_stv ? w_st_id : '0;
    w_nxt_flush   = w_run && w_redir;
    w_nxt_rpc     = w_nxt_flush ? w_redir_pc : '0;
    w_nxt_head    = r_head;
    if (w_run)
      w_nxt_head  = (w_head_sum >= (ROB_IDX_W+1)'(NO_ROB)) ?
                    ROB_IDX_W'(w_head_sum - (ROB_IDX_W+1)'(NO_ROB)) : w_head_sum[ROB_IDX_W-1:0];
    w_nxt_retired = r_retired + (w_run ? 32'(w_ret_n) : 32'd0);
  end

  // Output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head    <= '0;
      r_cv      <= '0;
      r_cid     <= '0;
      r_stv     <= 1'b0;
      r_stid    <= '0;
      r_flush   <= 1'b0;
      r_rpc     <= '0;
      r_retired <= '0;
    end else begin
      r_head    <= w_nxt_head;
      r_cv      <= w_nxt_cv;
      r_cid     <= w_nxt_cid;
      r_stv     <= w_nxt_stv;
      r_stid    <= w_nxt_stid;
      r_flush   <= w_nxt_flush;
      r_rpc     <= w_nxt_rpc;
      r_retired <= w_nxt_retired;
    end
  end

  assign o_rob_head         = r_head;
  assign o_commit_valid     = r_cv;
  assign o_commit_rob_id    = r_cid;
  assign o_st_commit_valid  = r_stv;
  assign o_st_commit_rob_id = r_stid;
  assign o_flush            = r_flush;
  assign o_redirect_pc      = r_rpc;
  assign o_retired_count    = r_retired;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Testbench for rob_commit_unit: directed scenarios plus randomized traffic,
// all checked against an abstract retirement model kept in the bench.
module tb_rob_commit_unit;
  localparam int IW = 3;
  localparam int NR = 48;
  localparam int RC = 4;
  localparam int XW = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     valid, ready, st, mp, ex, vi;
  logic [NR*32-1:0]  pc, tgt;
  logic              st_rdy;
  logic              stv;
  logic [XW-1:0]     stid, head;
  logic [IW-1:0]     cv;
  logic [IW*XW-1:0]  cid;
  logic              flush;
  logic [31:0]       rpc, rcnt;

  rob_commit_unit #(.ISSUE_WIDTH(IW), .NO_ROB(NR), .RECOVER_CYCLES(RC)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rob_valid(valid), .i_rob_ready(ready), .i_rob_is_store(st),
    .i_rob_mispredict(mp), .i_rob_exception(ex), .i_rob_violation(vi),
    .i_rob_pc(pc), .i_rob_target(tgt), .i_st_commit_ready(st_rdy),
    .o_st_commit_valid(stv), .o_st_commit_rob_id(stid),
    .o_commit_valid(cv), .o_commit_rob_id(cid), .o_rob_head(head),
    .o_flush(flush), .o_redirect_pc(rpc), .o_retired_count(rcnt));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  int          m_head, m_dead;
  int unsigned m_cnt;
  logic [IW-1:0] e_cv;
  int          e_id [IW];
  logic        e_stv, e_flush;
  int          e_stid;
  logic [31:0] e_rpc;

  // Apply the retirement rules to the current ROB image and advance the model.
  function automatic void predict();
    int n, idx;
    bit stop, sseen;
    e_cv = '0; e_stv = 0; e_stid = 0; e_flush = 0; e_rpc = '0;
    for (int k = 0; k < IW; k++) e_id[k] = 0;
    if (m_dead > 0) begin m_dead--; return; end
    n = 0; stop = 0; sseen = 0;
    for (int k = 0; k < IW; k++) begin
      if (stop) break;
      idx = (m_head + k) % NR;
      if (!(valid[idx] && ready[idx])) stop = 1;
      else if (ex[idx] || vi[idx]) begin e_flush = 1; e_rpc = pc[idx*32 +: 32]; stop = 1; end
      else if (st[idx] && (sseen || !st_rdy)) stop = 1;
      else begin
        e_cv[k] = 1; e_id[k] = idx; n++;
        if (st[idx]) begin sseen = 1; e_stv = 1; e_stid = idx; end
        if (mp[idx]) begin e_flush = 1; e_rpc = tgt[idx*32 +: 32]; stop = 1; end
      end
    end
    // flush edge is followed by one FLUSH cycle and RC recovery cycles
    if (e_flush) m_dead = RC + 1;
    m_head = (m_head + n) % NR;
    m_cnt  = m_cnt + n;
  endfunction

  task automatic model_reset();
    m_head = 0; m_cnt = 0; m_dead = 0;
  endtask

  task automatic tick();
    predict();
    @(posedge clk); #1;
  endtask

  task automatic clear_rob();
    valid = '0; ready = '0; st = '0; mp = '0; ex = '0; vi = '0;
  endtask

  task automatic set_alu(input int idx);
    valid[idx] = 1'b1; ready[idx] = 1'b1;
  endtask

  // Retire plain entries until the head reaches target (bounded).
  task automatic advance_to(input int target);
    int guard = 0;
    while (m_head != target && guard < 60) begin
      clear_rob();
      for (int i = m_head; i != target; i = (i + 1) % NR) set_alu(i);
      st_rdy = 1'b1;
      tick();
      guard++;
    end
    clear_rob();
    n_total++;
    if (head !== XW'(target)) $display("FAIL advance_head got=%0d want=%0d", head, target);
    else n_pass++;
  endtask

  task automatic test_reset();
    clear_rob();
    for (int i = 0; i < 6; i++) set_alu(i);
    st_rdy = 1'b1; pc = '0; tgt = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({stv, stid, cv, cid, head, flush, rpc, rcnt} !== '0)
      $display("FAIL reset_outputs got cv=%b head=%0d flush=%b cnt=%0d want all 0", cv, head, flush, rcnt);
    else n_pass++;
    rst = 1'b0;
    model_reset();
    clear_rob();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) set_alu(i);
    tick();
    n_total++;
    if (cv !== 3'b111 || cid !== {6'd2, 6'd1, 6'd0})
      $display("FAIL basic_group1 got cv=%b ids=%h want cv=111 ids 0,1,2", cv, cid);
    else n_pass++;
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;
    tick();
    n_total++;
    if (cv !== 3'b001 || cid[XW-1:0] !== 6'd3 || head !== 6'd4 || rcnt !== 32'd4)
      $display("FAIL basic_group2 got cv=%b id0=%0d head=%0d cnt=%0d want 001/3/4/4", cv, cid[XW-1:0], head, rcnt);
    else n_pass++;
    clear_rob();
    tick();
    n_total++;
    if (cv !== 3'b000 || head !== 6'd4)
      $display("FAIL basic_empty got cv=%b head=%0d want 000/4", cv, head);
    else n_pass++;
  endtask

  task automatic test_wrap();
    advance_to(46);
    set_alu(46); set_alu(47); set_alu(0);
    tick();
    n_total++;
    if (cv !== 3'b111 || cid !== {6'd0, 6'd47, 6'd46} || head !== 6'd1)
      $display("FAIL wrap got cv=%b ids=%h head=%0d want 111 ids 46,47,0 head 1", cv, cid, head);
    else n_pass++;
    clear_rob();
  endtask

  task automatic test_store();
    advance_to(5);
    set_alu(5); set_alu(6); st[5] = 1'b1; st[6] = 1'b1;
    st_rdy = 1'b0;
    tick();
    n_total++;
    if (cv !== 3'b000 || stv !== 1'b0 || head !== 6'd5)
      $display("FAIL store_blocked got cv=%b stv=%b head=%0d want 000/0/5", cv, stv, head);
    else n_pass++;
    st_rdy = 1'b1;
    tick();
    n_total++;
    if (cv !== 3'b001 || cid[XW-1:0] !== 6'd5 || stv !== 1'b1 || stid !== 6'd5)
      $display("FAIL store_first got cv=%b id=%0d stv=%b stid=%0d want 001/5/1/5", cv, cid[XW-1:0], stv, stid);
    else n_pass++;
    tick();
    n_total++;
    if (cv !== 3'b001 || cid[XW-1:0] !== 6'd6 || stv !== 1'b1 || stid !== 6'd6 || head !== 6'd7)
      $display("FAIL store_second got cv=%b id=%0d stid=%0d head=%0d want 001/6/6/7", cv, cid[XW-1:0], stid, head);
    else n_pass++;
    clear_rob();
  endtask

  task automatic test_mispredict();
    advance_to(10);
    for (int i = 10; i < 16; i++) set_alu(i);
    mp[11] = 1'b1; tgt[11*32 +: 32] = 32'h200;
    tick();
    n_total++;
    if (cv !== 3'b011 || cid[2*XW-1:0] !== {6'd11, 6'd10} || flush !== 1'b1 ||
        rpc !== 32'h200 || head !== 6'd12)
      $display("FAIL mispredict got cv=%b flush=%b rpc=%h head=%0d want 011/1/200/12", cv, flush, rpc, head);
    else n_pass++;
    for (int c = 0; c < RC + 1; c++) begin
      tick();
      n_total++;
      if (cv !== 3'b000 || flush !== 1'b0 || stv !== 1'b0 || head !== 6'd12)
        $display("FAIL recover_quiet cycle=%0d got cv=%b flush=%b head=%0d want 000/0/12", c, cv, flush, head);
      else n_pass++;
    end
    tick();
    n_total++;
    if (cv !== 3'b111 || cid[XW-1:0] !== 6'd12)
      $display("FAIL resume got cv=%b id0=%0d want 111/12", cv, cid[XW-1:0]);
    else n_pass++;
    clear_rob();
  endtask

  task automatic test_exception();
    advance_to(20);
    set_alu(20); set_alu(21);
    ex[20] = 1'b1; vi[20] = 1'b1; st[20] = 1'b1; mp[20] = 1'b1;
    pc[20*32 +: 32] = 32'h80; tgt[20*32 +: 32] = 32'h444;
    tick();
    n_total++;
    if (cv !== 3'b000 || flush !== 1'b1 || rpc !== 32'h80 || head !== 6'd20 || stv !== 1'b0)
      $display("FAIL exception got cv=%b flush=%b rpc=%h head=%0d stv=%b want 000/1/80/20/0", cv, flush, rpc, head, stv);
    else n_pass++;
    clear_rob();
    repeat (RC + 1) tick();
  endtask

  task automatic test_rst_recover();
    advance_to(30);
    set_alu(30); mp[30] = 1'b1; tgt[30*32 +: 32] = 32'h1234;
    tick();
    clear_rob();
    repeat (2) tick();
    rst = 1'b1;
    #1;
    n_total++;
    if ({stv, stid, cv, cid, head, flush, rpc, rcnt} !== '0)
      $display("FAIL rst_async got head=%0d cnt=%0d cv=%b want all 0", head, rcnt, cv);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    set_alu(0); set_alu(1);
    tick();
    n_total++;
    if (cv !== 3'b011 || head !== 6'd2 || rcnt !== 32'd2)
      $display("FAIL rst_resume got cv=%b head=%0d cnt=%0d want 011/2/2", cv, head, rcnt);
    else n_pass++;
    clear_rob();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        valid[i] = ($urandom_range(0, 9) < 9);
        ready[i] = ($urandom_range(0, 9) < 8);
        st[i]    = ($urandom_range(0, 9) < 2);
        mp[i]    = ($urandom_range(0, 99) < 5);
        ex[i]    = ($urandom_range(0, 99) < 3);
        vi[i]    = ($urandom_range(0, 99) < 3);
        pc[i*32 +: 32]  = $urandom;
        tgt[i*32 +: 32] = $urandom;
      end
      st_rdy = ($urandom_range(0, 9) < 7);
      tick();
      n_total++;
      if (cv !== e_cv) $display("FAIL rnd_cv cyc=%0d got=%b want=%b", c, cv, e_cv);
      else n_pass++;
      for (int k = 0; k < IW; k++) if (e_cv[k]) begin
        n_total++;
        if (cid[k*XW +: XW] !== XW'(e_id[k]))
          $display("FAIL rnd_id cyc=%0d slot=%0d got=%0d want=%0d", c, k, cid[k*XW +: XW], e_id[k]);
        else n_pass++;
      end
      n_total++;
      if (stv !== e_stv || (e_stv && stid !== XW'(e_stid)))
        $display("FAIL rnd_store cyc=%0d got=%b/%0d want=%b/%0d", c, stv, stid, e_stv, e_stid);
      else n_pass++;
      n_total++;
      if (flush !== e_flush || (e_flush && rpc !== e_rpc))
        $display("FAIL rnd_flush cyc=%0d got=%b/%h want=%b/%h", c, flush, rpc, e_flush, e_rpc);
      else n_pass++;
      n_total++;
      if (head !== XW'(m_head) || rcnt !== m_cnt)
        $display("FAIL rnd_head cyc=%0d got=%0d/%0d want=%0d/%0d", c, head, rcnt, m_head, m_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_wrap();
    test_store();
    test_mispredict();
    test_exception();
    test_rst_recover();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
